// File: rtl/bcd_to_binary_converter.sv
// bcd_to_binary_converter
// Converts a latched 4-digit BCD word into a clamped 16-bit binary value.
// The conversion is iterative: one digit per clock, thousands digit first,
// computing acc = acc*10 + digit.
// The result is valid from the one-cycle done pulse until the next accepted start.
// Optional feature macro: BCD_ERR_DIGIT_EN adds a per-digit invalid flag
// output, err_digit[3:0].
module bcd_to_binary_converter #(
  parameter logic [15:0] MIN_VALUE = 16'd0,
  parameter logic [15:0] MAX_VALUE = 16'd9999
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0][3:0] bcd_digits,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [15:0]     value,
  output logic            error,
  output logic            clamped
`ifdef BCD_ERR_DIGIT_EN
  ,
  output logic [3:0]      err_digit
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  logic [3:0][3:0] latched;
  logic [16:0]     acc;
  logic [1:0]      idx;

  logic [3:0]      digit_bad;
  logic            any_bad;
  logic [3:0]      cur_digit;
  logic [16:0]     acc_step;
  logic [15:0]     final_value;
  logic            final_clamped;

  // A digit is invalid when its nibble lies in the range 10..15.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit_check
      assign digit_bad[gi] = (latched[gi] > 4'd9);
    end
  endgenerate

  assign any_bad   = |digit_bad;
  assign cur_digit = latched[idx];

  // The worst case, four digits of 15, gives 16665, so 17 bits never wrap.
  assign acc_step  = (acc * 17'd10) + {13'd0, cur_digit};

  // Final result selection: an invalid digit forces MAX_VALUE without flagging
  // a clamp; a valid result outside the range is clamped to the bound it crossed.
  always_comb begin
    final_value   = acc_step[15:0];
    final_clamped = 1'b0;
    if (any_bad) begin
      final_value   = MAX_VALUE;
      final_clamped = 1'b0;
    end else if (acc_step > {1'b0, MAX_VALUE}) begin
      final_value   = MAX_VALUE;
      final_clamped = 1'b1;
    end else if (acc_step < {1'b0, MIN_VALUE}) begin
      final_value   = MIN_VALUE;
      final_clamped = 1'b1;
    end
  end

  // Control FSM with registered status outputs.
  // Result registers change only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= 16'd0;
      error     <= 1'b0;
      clamped   <= 1'b0;
      acc       <= 17'd0;
      idx       <= 2'd3;
      latched   <= '0;
`ifdef BCD_ERR_DIGIT_EN
      err_digit <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            latched <= bcd_digits;
            acc     <= 17'd0;
            idx     <= 2'd3;
            state   <= CONVERT;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        CONVERT: begin
          acc <= acc_step;
          idx <= idx - 2'd1;
          if (idx == 2'd0) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            ready     <= 1'b1;
            value     <= final_value;
            error     <= any_bad;
            clamped   <= final_clamped;
`ifdef BCD_ERR_DIGIT_EN
            err_digit <= digit_bad;
`endif
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
